// File: rtl/ifu_prefetch_pkg.sv
// Shared widths, reset PC and fetch entry layout for the prefetch stage.
package ifu_prefetch_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] INST_ALIGN   = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_addr(
      input logic [XLEN-1:0] a
   );
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs.
module ifu_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       rdata
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    push_w;
   logic [CW-1:0]    pop_w;

   assign push_w = {{(CW-1){1'b0}}, push};
   assign pop_w  = {{(CW-1){1'b0}}, pop};
   assign rdata  = mem[rd_ptr];

   // Flush wins over push and pop; storage is left as-is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + push_w - pop_w;
      end
   end

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch stage: PC, one request per cycle, credit-limited prefetch FIFO.
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] inst_addr_o,
   output logic        inst_req_o,
   input  logic        inst_ack_i,
   input  logic [31:0] inst_data_i,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   output logic        if_valid_o,
   input  logic        if_ready_i,
   output logic [31:0] if_inst_o,
   output logic [31:0] if_pc_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pend_pc;
   logic            pending;
   logic            rst_done;
   logic [CW-1:0]   count;
   logic [CW:0]     credit;
   logic            raw_pop;
   logic            pop;
   logic            push;
   logic            accept;
   fetch_entry_t    wentry;
   fetch_entry_t    head;

   assign if_valid_o = (count != '0);
   assign raw_pop    = if_valid_o & if_ready_i;

   // Entries held plus the one in flight, less what leaves this cycle.
   assign credit = {1'b0, count}
                 + {{CW{1'b0}}, pending}
                 - {{CW{1'b0}}, raw_pop};

   assign inst_req_o  = rst_done & (jump_i | (credit < CAP));
   assign inst_addr_o = jump_i ? align_addr(jump_addr_i) : pc;
   assign accept      = inst_req_o & inst_ack_i;

   // A jump drops this cycle's response and any pop.
   assign push = pending & ~jump_i;
   assign pop  = raw_pop & ~jump_i;

   assign wentry = '{pc: pend_pc, inst: inst_data_i};

   ifu_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (jump_i),
      .wdata (wentry),
      .count (count),
      .rdata (head)
   );

   assign if_pc_o   = head.pc;
   assign if_inst_o = head.inst;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= align_addr(RESET_PC);
         pend_pc  <= '0;
         pending  <= 1'b0;
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         pending  <= accept;
         pend_pc  <= inst_addr_o;
         pc       <= accept ? inst_addr_o + INST_ALIGN
                            : inst_addr_o;
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed plus random bench for ifu_prefetch against a queue model.
module tb_ifu_prefetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk;
   logic        rst_n;
   logic [31:0] inst_addr_o;
   logic        inst_req_o;
   logic        inst_ack_i;
   logic [31:0] inst_data_i;
   logic        jump_i;
   logic [31:0] jump_addr_i;
   logic        if_valid_o;
   logic        if_ready_i;
   logic [31:0] if_inst_o;
   logic [31:0] if_pc_o;

   ifu_prefetch #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .inst_addr_o (inst_addr_o),
      .inst_req_o  (inst_req_o),
      .inst_ack_i  (inst_ack_i),
      .inst_data_i (inst_data_i),
      .jump_i      (jump_i),
      .jump_addr_i (jump_addr_i),
      .if_valid_o  (if_valid_o),
      .if_ready_i  (if_ready_i),
      .if_inst_o   (if_inst_o),
      .if_pc_o     (if_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: expected FIFO contents as {pc, inst} words.
   logic [31:0] m_pc;
   logic [63:0] m_q[$];
   logic        m_pend;
   logic [31:0] m_pend_addr;
   logic        m_rst_done;

   // RAM side, driven from the DUT's real handshake.
   logic        r_pend;
   logic [31:0] r_addr;

   function automatic logic [31:0] ram(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc        = RESET_PC;
      m_q.delete();
      m_pend      = 1'b0;
      m_pend_addr = '0;
      m_rst_done  = 1'b0;
      r_pend      = 1'b0;
      r_addr      = '0;
   endtask

   task automatic cycle(input logic        ack,
                        input logic        rdy,
                        input logic        jmp,
                        input logic [31:0] ja);
      logic [31:0] e_addr;
      logic        e_req;
      logic        e_pop;
      logic        acc;
      logic        nr_pend;
      logic [31:0] nr_addr;
      int          used;
      inst_ack_i  = ack;
      if_ready_i  = rdy;
      jump_i      = jmp;
      jump_addr_i = ja;
      inst_data_i = r_pend ? ram(r_addr) : $urandom;
      #1;
      e_pop  = (m_q.size() != 0) && rdy;
      e_addr = jmp ? {ja[31:2], 2'b00} : m_pc;
      used   = m_q.size() + int'(m_pend) - int'(e_pop);
      e_req  = m_rst_done && (jmp || used < DEPTH);
      chk("addr", inst_addr_o, e_addr);
      chk("req", 32'(inst_req_o), 32'(e_req));
      chk("valid", 32'(if_valid_o), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         chk("head_pc", if_pc_o, m_q[0][63:32]);
         chk("head_inst", if_inst_o, m_q[0][31:0]);
      end
      nr_pend = inst_req_o & inst_ack_i;
      nr_addr = inst_addr_o;
      acc     = e_req && ack;
      if (jmp) begin
         m_q.delete();
      end else begin
         if (e_pop) void'(m_q.pop_front());
         if (m_pend) m_q.push_back({m_pend_addr, ram(m_pend_addr)});
      end
      m_pend      = acc;
      m_pend_addr = e_addr;
      m_pc        = acc ? e_addr + 32'd4 : e_addr;
      m_rst_done  = 1'b1;
      @(posedge clk);
      #1;
      r_pend = nr_pend;
      r_addr = nr_addr;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req"}, 32'(inst_req_o), 32'd0);
      chk({tag, "_valid"}, 32'(if_valid_o), 32'd0);
      chk({tag, "_pc"}, if_pc_o, 32'd0);
      chk({tag, "_inst"}, if_inst_o, 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      inst_ack_i  = 1'b0;
      if_ready_i  = 1'b0;
      jump_i      = 1'b0;
      jump_addr_i = '0;
      inst_data_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_checks("rst");
      chk("rst_addr", inst_addr_o, RESET_PC);
      rst_n = 1'b1;

      // Cold start: first head two cycles after first accept.
      repeat (3) cycle(1, 1, 0, 0);
      chk("first_valid", 32'(if_valid_o), 32'd1);
      chk("first_pc", if_pc_o, 32'h0);
      repeat (2) cycle(1, 1, 0, 0);

      // RAM stalls.
      repeat (3) cycle(0, 1, 0, 0);
      repeat (3) cycle(1, 1, 0, 0);

      // Decode stalls: FIFO fills, requests stop.
      repeat (5) cycle(1, 0, 0, 0);
      chk("full_req", 32'(inst_req_o), 32'd0);
      repeat (5) cycle(1, 1, 0, 0);

      // Jump with FIFO full.
      repeat (3) cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 32'h100);
      chk("jump_t1_valid", 32'(if_valid_o), 32'd0);
      cycle(1, 1, 0, 0);
      chk("jump_head_pc", if_pc_o, 32'h100);
      repeat (3) cycle(1, 1, 0, 0);

      // Misaligned jump while RAM stalls.
      cycle(0, 1, 1, 32'h103);
      cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 0, 0);
      chk("jump2_head_pc", if_pc_o, 32'h100);

      // Back-to-back jumps, then PC wrap.
      cycle(1, 1, 1, 32'h200);
      cycle(1, 1, 1, 32'h300);
      repeat (3) cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 32'hFFFF_FFF8);
      repeat (6) cycle(1, 1, 0, 0);

      // Asynchronous reset mid-stream with a full FIFO.
      repeat (4) cycle(1, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      reset_checks("midrst");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) cycle(1, 1, 0, 0);
      chk("restart_pc", if_pc_o, RESET_PC);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom % 4) != 0,
               ($urandom % 4) != 0,
               ($urandom % 12) == 0,
               $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction fetch/prefetch stage directly upstream of the instruction RAM fetch port.
- Holds the PC and issues one fetch per cycle to the RAM.
- Captures the registered RAM read data one cycle after each accepted request and stores {pc, inst} pairs in a small FIFO.
- Presents the FIFO head to decode with a valid/ready handshake; a jump from execute redirects the PC and flushes everything in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- inst_addr_o  out  32  fetch address to the RAM; bits [1:0] always 0
- inst_req_o  out  1  fetch request
- inst_ack_i  in  1  RAM can accept a request this cycle
- inst_data_i  in  32  RAM read data, valid in the cycle after an accepted request
- jump_i  in  1  redirect/flush strobe from execute
- jump_addr_i  in  32  redirect target
- if_valid_o  out  1  FIFO head valid
- if_ready_i  in  1  decode accepts the head
- if_inst_o  out  32  head instruction
- if_pc_o  out  32  head PC

Behaviour:
- Reset values:
  - pc = RESET_PC.
  - FIFO count = 0; pending = 0.
  - inst_req_o = 0 while rst_n is low; if_valid_o = 0.
  - if_inst_o and if_pc_o = 0.
- Accept rule: a request is accepted in cycle T when inst_req_o & inst_ack_i.
  - pending <= 1 for T+1; otherwise pending <= 0.
  - In T+1, inst_data_i is pushed with its PC, unless dropped by a jump.
  - inst_data_i is never sampled in any other cycle.
- Address and PC:
  - inst_addr_o = jump_i ? {jump_addr_i[31:2], 2'b00} : pc.
  - On accept: pc <= inst_addr_o + 4.
  - On no accept: pc <= inst_addr_o, i.e. the same address is retried or the jump target is held.
  - The PC wraps modulo 2^32.
- Credit rule: inst_req_o = rst_done & (jump_i | (count + pending - pop < DEPTH)).
  - pop = if_valid_o & if_ready_i.
  - The FIFO can never overflow.
  - Throughput with ready held high is 1 instruction per cycle.
- Latency: request accepted in T gives if_valid_o in T+2 (no bypass).
- FIFO push/pop:
  - Push in the same cycle as pop is allowed at full and at empty (empty: no pop possible).
  - Ordering is strictly in address order.
- Jump in cycle T:
  - The FIFO is cleared at the T->T+1 edge.
  - Any response arriving in T is dropped, and any pop in T is ignored.
  - A request for the target may be issued and accepted in T; its data is pushed in T+1 as normal.
  - if_valid_o is 0 in T+1 and becomes 1 no earlier than T+2.
- Jump while inst_ack_i is low: the target is latched into pc and retried each cycle until accepted.
- Back-to-back jumps: the last one wins; each drops the previous cycle's response.
- rst_done is a register set 1 cycle after reset release, so inst_req_o stays 0 in the first clock after reset.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no partial push.
- Outputs are registered from FIFO storage. Only inst_req_o and inst_addr_o have combinational paths, from jump_i, jump_addr_i and if_ready_i.

Decomposition:
- Shared package/defines:
  - Address and instruction bus widths (32).
  - RESET_PC default.
  - Instruction alignment constant (4).
- Sub-module ifu_fifo: synchronous FIFO with DEPTH and WIDTH = 64 parameters.
  - Ports: push, pop, flush (flush has priority over push and pop).
  - Outputs: count, head data.
- Top level holds pc, pending, rst_done, the credit logic and the jump mux.

Test Plan:
- Reset release, ack = 1, ready = 1 → inst_addr_o = 0x0, 0x4, 0x8 on consecutive cycles starting cycle 2 after release; if_valid_o first high 2 cycles after the first accept with if_pc_o = 0x0; then one instruction per cycle.
- ack = 0 for 3 cycles at address 0x8 → inst_addr_o stays 0x8, pc unchanged, no push; resumes at 0x8 then 0xC.
- ready = 0 → FIFO holds DEPTH = 2 entries (0x0, 0x4), inst_req_o drops, no overflow; ready = 1 → heads 0x0, 0x4, 0x8 delivered in order with no gap beyond the credit rule.
- FIFO full plus pending, jump_i with jump_addr_i = 0x100 → next if_valid_o shows if_pc_o = 0x100, no stale 0x4 or 0x8 delivered, following PC 0x104.
- jump_addr_i = 0x103 while ack = 0 for 2 cycles → inst_addr_o = 0x100 held, accepted when ack = 1; head PC = 0x100.
- Assert rst_n low mid-stream with the FIFO full → if_valid_o = 0, inst_req_o = 0 immediately; after release fetch restarts at RESET_PC.
